// File: rtl/seg_decoder.sv
// Decodes a multiplexed 4-digit active-low 7-segment bus back into digit nibbles.
// Define SEG_DP_CAPTURE_EN to also capture the decimal points (seg_in[7]) onto dp_out.
module seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  dig_en,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  dp_out
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      seg_prev_q;
    logic [3:0]      en_prev_q;
    logic [3:0]      mask_q, mask_d;
    logic [3:0][3:0] nib_q;
    logic [3:0]      err_q;
    logic [3:0]      dp_q;
    logic            load_q;
    logic [15:0]     digits_q;
    logic [3:0]      dp_out_q;
    logic            frame_valid_q;
    logic            frame_err_q;

    logic [7:0]      seg_cmp;
    logic            dp_bit;
    logic [2:0]      strb;
    logic            strb_vld;
    logic [1:0]      strb_idx;
    logic [4:0]      dec;
    logic            changed;
    logic            capture;
    logic [3:0]      onehot;
    logic [3:0]      mask_base;
    logic            frame_done;

    // {error, nibble} for a g..a pattern; unknown patterns map to E with the error mark
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h0E:   r = 5'h0F;
            default: r = 5'h1E;
        endcase
        return r;
    endfunction

    // {valid, index}: valid only when exactly one strobe is pulled low
    function automatic logic [2:0] strobe_dec(input logic [3:0] en);
        logic [2:0] r;
        case (en)
            4'b1110: r = 3'b100;
            4'b1101: r = 3'b101;
            4'b1011: r = 3'b110;
            4'b0111: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

`ifdef SEG_DP_CAPTURE_EN
    assign seg_cmp = seg_in;
    assign dp_bit  = ~seg_in[7];
`else
    logic unused_dp;
    assign unused_dp = seg_in[7];
    assign seg_cmp   = {1'b0, seg_in[6:0]};
    assign dp_bit    = 1'b0;
`endif

    assign strb     = strobe_dec(dig_en);
    assign strb_vld = strb[2];
    assign strb_idx = strb[1:0];
    assign dec      = decode_seg(seg_in[6:0]);
    assign changed  = (seg_cmp != seg_prev_q) || (dig_en != en_prev_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (strb_vld) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE, HOLD: begin
                if (changed) begin
                    state_d = strb_vld ? SETTLE : IDLE;
                    cnt_d   = '0;
                end else if (state_q == SETTLE) begin
                    if (cnt_q == CNT_LAST) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pending frame load clears the mask first, so a coincident capture opens the next frame
    always_comb begin
        onehot     = 4'b0001 << strb_idx;
        mask_base  = load_q ? 4'h0 : mask_q;
        mask_d     = capture ? (mask_base | onehot) : mask_base;
        frame_done = capture && ((mask_base | onehot) == 4'hF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            seg_prev_q    <= '0;
            en_prev_q     <= '0;
            mask_q        <= '0;
            nib_q         <= '0;
            err_q         <= '0;
            dp_q          <= '0;
            load_q        <= 1'b0;
            digits_q      <= '0;
            dp_out_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_prev_q <= seg_cmp;
            en_prev_q  <= dig_en;
            mask_q     <= mask_d;
            load_q     <= frame_done;
            if (capture) begin
                nib_q[strb_idx] <= dec[3:0];
                err_q[strb_idx] <= dec[4];
                dp_q[strb_idx]  <= dp_bit;
            end
            frame_valid_q <= load_q;
            frame_err_q   <= load_q & (|err_q);
            if (load_q) begin
                digits_q <= nib_q;
                dp_out_q <= dp_q;
            end
        end
    end

    assign digits      = digits_q;
    assign dp_out      = dp_out_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule
